// File: rtl/bicg_pkg.sv
// Shared constants, FSM state encoding and address helper for the BiCG core.
// Optional feature macro: BICG_ZERO_INIT_EN (zero s and q before accumulating).
package bicg_pkg;

  localparam int N           = 8;
  localparam int WIDTH       = 32;
  localparam int IDX         = 4;
  localparam int CNT_W       = 3;
  localparam int ROW_CYCLES  = 28;
  localparam int ZERO_CYCLES = 16;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  typedef enum logic [3:0] {
    IDLE,
    ZERO_S,
    LD_R,
    RD,
    ACC,
    WR_WAIT,
    WR_Q,
    WR_Q_WAIT,
    DONE
  } state_t;

  // Loop counters only span 0..7, so the top address bit is always 0.
  function automatic logic [IDX-1:0] to_addr(input logic [CNT_W-1:0] k);
    return {1'b0, k};
  endfunction

endpackage

// File: rtl/bicg_mac.sv
// Combinational dual multiply-add: s_new = s + r*a and q_new = q + a*p,
// both wrapping modulo 2^WIDTH.
module bicg_mac
  import bicg_pkg::*;
(
  input  logic signed [WIDTH-1:0] s_in,
  input  logic signed [WIDTH-1:0] r_in,
  input  logic signed [WIDTH-1:0] a_in,
  input  logic signed [WIDTH-1:0] q_in,
  input  logic signed [WIDTH-1:0] p_in,
  output logic signed [WIDTH-1:0] s_new,
  output logic signed [WIDTH-1:0] q_new
);

  // Product and sum are evaluated at WIDTH bits, so overflow simply wraps.
  function automatic logic signed [WIDTH-1:0] mac_wrap(
    input logic signed [WIDTH-1:0] acc,
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] y
  );
    logic signed [WIDTH-1:0] prod;
    prod = x * y;
    return acc + prod;
  endfunction

  assign s_new = mac_wrap(s_in, r_in, a_in);
  assign q_new = mac_wrap(q_in, a_in, p_in);

endmodule

// File: rtl/bicg_main.sv
// BiCG sub-kernel core: s = A^T*r and q = A*p over external 8x8 / 8-entry memories.
// Build option BICG_ZERO_INIT_EN: clear s and q first; otherwise accumulate onto them.
module bicg_main
  import bicg_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  output logic             done,

  output logic [IDX-1:0]   A_int_addr0,
  output logic [IDX-1:0]   A_int_addr1,
  output logic [WIDTH-1:0] A_int_write_data,
  output logic             A_int_write_en,
  output logic             A_int_read_en,
  input  logic [WIDTH-1:0] A_int_read_data,
  input  logic             A_int_read_done,
  input  logic             A_int_write_done,

  output logic [IDX-1:0]   p_int_addr0,
  output logic [WIDTH-1:0] p_int_write_data,
  output logic             p_int_write_en,
  output logic             p_int_read_en,
  input  logic [WIDTH-1:0] p_int_read_data,
  input  logic             p_int_read_done,
  input  logic             p_int_write_done,

  output logic [IDX-1:0]   q_int_addr0,
  output logic [WIDTH-1:0] q_int_write_data,
  output logic             q_int_write_en,
  output logic             q_int_read_en,
  input  logic [WIDTH-1:0] q_int_read_data,
  input  logic             q_int_read_done,
  input  logic             q_int_write_done,

  output logic [IDX-1:0]   r_int_addr0,
  output logic [WIDTH-1:0] r_int_write_data,
  output logic             r_int_write_en,
  output logic             r_int_read_en,
  input  logic [WIDTH-1:0] r_int_read_data,
  input  logic             r_int_read_done,
  input  logic             r_int_write_done,

  output logic [IDX-1:0]   s_int_addr0,
  output logic [WIDTH-1:0] s_int_write_data,
  output logic             s_int_write_en,
  output logic             s_int_read_en,
  input  logic [WIDTH-1:0] s_int_read_data,
  input  logic             s_int_read_done,
  input  logic             s_int_write_done
);

  state_t           state;
  logic [CNT_W-1:0] i;
  logic [CNT_W-1:0] j;
  logic             phase;
  logic [WIDTH-1:0] r_i;
  logic [WIDTH-1:0] q_acc;
  logic [WIDTH-1:0] s_new;
  logic [WIDTH-1:0] q_new;
  logic             rd_ok;
  logic             ld_ok;
  logic             unused_inputs;

`ifdef BICG_ZERO_INIT_EN
  localparam state_t START = ZERO_S;
  assign ld_ok         = r_int_read_done;
  assign unused_inputs = ^{A_int_write_done, p_int_write_done, r_int_write_done,
                           q_int_read_data, q_int_read_done};
`else
  localparam state_t START = LD_R;
  assign ld_ok         = r_int_read_done & q_int_read_done;
  assign unused_inputs = ^{A_int_write_done, p_int_write_done, r_int_write_done};
`endif

  assign rd_ok = A_int_read_done & p_int_read_done & s_int_read_done;

  bicg_mac u_mac (
    .s_in  (s_int_read_data),
    .r_in  (r_i),
    .a_in  (A_int_read_data),
    .q_in  (q_acc),
    .p_in  (p_int_read_data),
    .s_new (s_new),
    .q_new (q_new)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      phase <= 1'b0;
      r_i   <= '0;
      q_acc <= '0;
    end else begin
      case (state)
        IDLE: begin
          i     <= '0;
          j     <= '0;
          phase <= 1'b0;
          if (go) state <= START;
        end
        ZERO_S: begin
          if (!phase) begin
            phase <= 1'b1;
          end else if (s_int_write_done) begin
            phase <= 1'b0;
            if (j == LAST_IDX) begin
              j     <= '0;
              state <= LD_R;
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        LD_R: begin
          if (!phase) begin
            phase <= 1'b1;
`ifdef BICG_ZERO_INIT_EN
            q_acc <= '0;
`endif
          end else if (ld_ok) begin
            phase <= 1'b0;
            r_i   <= r_int_read_data;
`ifndef BICG_ZERO_INIT_EN
            q_acc <= q_int_read_data;
`endif
            state <= RD;
          end
        end
        RD: state <= ACC;
        ACC: begin
          if (rd_ok) begin
            q_acc <= q_new;
            state <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (s_int_write_done) begin
            if (j == LAST_IDX) begin
              j     <= '0;
              state <= WR_Q;
            end else begin
              j     <= j + 1'b1;
              state <= RD;
            end
          end
        end
        WR_Q: state <= WR_Q_WAIT;
        WR_Q_WAIT: begin
          if (q_int_write_done) begin
            if (i == LAST_IDX) begin
              i     <= '0;
              state <= DONE;
            end else begin
              i     <= i + 1'b1;
              state <= LD_R;
            end
          end
        end
        DONE: if (!go) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The s store in ACC depends on this cycle's read data, so port drive is decoded from state.
  always_comb begin
    A_int_addr0      = '0;
    A_int_addr1      = '0;
    A_int_read_en    = 1'b0;
    p_int_addr0      = '0;
    p_int_read_en    = 1'b0;
    q_int_addr0      = '0;
    q_int_write_data = '0;
    q_int_write_en   = 1'b0;
    q_int_read_en    = 1'b0;
    r_int_addr0      = '0;
    r_int_read_en    = 1'b0;
    s_int_addr0      = '0;
    s_int_write_data = '0;
    s_int_write_en   = 1'b0;
    s_int_read_en    = 1'b0;
    case (state)
      ZERO_S: begin
        s_int_addr0    = to_addr(j);
        s_int_write_en = !phase;
      end
      LD_R: begin
        r_int_addr0   = to_addr(i);
        r_int_read_en = !phase;
`ifndef BICG_ZERO_INIT_EN
        q_int_addr0   = to_addr(i);
        q_int_read_en = !phase;
`endif
      end
      RD: begin
        A_int_addr0   = to_addr(i);
        A_int_addr1   = to_addr(j);
        A_int_read_en = 1'b1;
        p_int_addr0   = to_addr(j);
        p_int_read_en = 1'b1;
        s_int_addr0   = to_addr(j);
        s_int_read_en = 1'b1;
      end
      ACC: begin
        A_int_addr0      = to_addr(i);
        A_int_addr1      = to_addr(j);
        p_int_addr0      = to_addr(j);
        s_int_addr0      = to_addr(j);
        s_int_write_data = s_new;
        s_int_write_en   = rd_ok;
      end
      WR_WAIT: s_int_addr0 = to_addr(j);
      WR_Q: begin
        q_int_addr0      = to_addr(i);
        q_int_write_data = q_acc;
        q_int_write_en   = 1'b1;
      end
      WR_Q_WAIT: q_int_addr0 = to_addr(i);
      default: ;
    endcase
  end

  assign done             = (state == DONE);
  assign A_int_write_data = '0;
  assign A_int_write_en   = 1'b0;
  assign p_int_write_data = '0;
  assign p_int_write_en   = 1'b0;
  assign r_int_write_data = '0;
  assign r_int_write_en   = 1'b0;

endmodule

// File: tb/tb_bicg_main.sv
// Self-checking bench for bicg_main: table of directed matrix/vector cases plus
// mid-run reset and go-handling sequences; adapts to BICG_ZERO_INIT_EN.
module tb_bicg_main;

`ifdef BICG_ZERO_INIT_EN
  localparam bit ZINIT = 1'b1;
`else
  localparam bit ZINIT = 1'b0;
`endif
  localparam int EXP_CYC = ZINIT ? 240 : 224;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, go, done;
  logic [3:0]  A_int_addr0, A_int_addr1, p_int_addr0, q_int_addr0, r_int_addr0, s_int_addr0;
  logic [31:0] A_int_write_data, p_int_write_data, q_int_write_data, r_int_write_data, s_int_write_data;
  logic        A_int_write_en, p_int_write_en, q_int_write_en, r_int_write_en, s_int_write_en;
  logic        A_int_read_en, p_int_read_en, q_int_read_en, r_int_read_en, s_int_read_en;
  logic [31:0] A_int_read_data = '0, p_int_read_data = '0, q_int_read_data = '0;
  logic [31:0] r_int_read_data = '0, s_int_read_data = '0;
  logic A_int_read_done = 1'b0, p_int_read_done = 1'b0, q_int_read_done = 1'b0;
  logic r_int_read_done = 1'b0, s_int_read_done = 1'b0;
  logic A_int_write_done = 1'b0, p_int_write_done = 1'b0, q_int_write_done = 1'b0;
  logic r_int_write_done = 1'b0, s_int_write_done = 1'b0;

  bicg_main dut (
    .clk(clk), .reset(reset), .go(go), .done(done),
    .A_int_addr0(A_int_addr0), .A_int_addr1(A_int_addr1),
    .A_int_write_data(A_int_write_data), .A_int_write_en(A_int_write_en),
    .A_int_read_en(A_int_read_en), .A_int_read_data(A_int_read_data),
    .A_int_read_done(A_int_read_done), .A_int_write_done(A_int_write_done),
    .p_int_addr0(p_int_addr0), .p_int_write_data(p_int_write_data),
    .p_int_write_en(p_int_write_en), .p_int_read_en(p_int_read_en),
    .p_int_read_data(p_int_read_data), .p_int_read_done(p_int_read_done),
    .p_int_write_done(p_int_write_done),
    .q_int_addr0(q_int_addr0), .q_int_write_data(q_int_write_data),
    .q_int_write_en(q_int_write_en), .q_int_read_en(q_int_read_en),
    .q_int_read_data(q_int_read_data), .q_int_read_done(q_int_read_done),
    .q_int_write_done(q_int_write_done),
    .r_int_addr0(r_int_addr0), .r_int_write_data(r_int_write_data),
    .r_int_write_en(r_int_write_en), .r_int_read_en(r_int_read_en),
    .r_int_read_data(r_int_read_data), .r_int_read_done(r_int_read_done),
    .r_int_write_done(r_int_write_done),
    .s_int_addr0(s_int_addr0), .s_int_write_data(s_int_write_data),
    .s_int_write_en(s_int_write_en), .s_int_read_en(s_int_read_en),
    .s_int_read_data(s_int_read_data), .s_int_read_done(s_int_read_done),
    .s_int_write_done(s_int_write_done)
  );

  // Memories: one-cycle read latency with done strobe; write commits at the edge.
  logic [31:0] a_mem [16][16];
  logic [31:0] p_mem [16];
  logic [31:0] r_mem [16];
  logic [31:0] q_mem [16];
  logic [31:0] s_mem [16];
  logic        pre_go = 1'b0;
  logic [31:0] pre_val = '0;
  int          viol = 0;

  always @(posedge clk) begin
    A_int_read_done  <= A_int_read_en;
    if (A_int_read_en) A_int_read_data <= a_mem[A_int_addr0][A_int_addr1];
    A_int_write_done <= A_int_write_en;
    p_int_read_done  <= p_int_read_en;
    if (p_int_read_en) p_int_read_data <= p_mem[p_int_addr0];
    p_int_write_done <= p_int_write_en;
    r_int_read_done  <= r_int_read_en;
    if (r_int_read_en) r_int_read_data <= r_mem[r_int_addr0];
    r_int_write_done <= r_int_write_en;
    q_int_read_done  <= q_int_read_en;
    if (q_int_read_en) q_int_read_data <= q_mem[q_int_addr0];
    q_int_write_done <= q_int_write_en;
    s_int_read_done  <= s_int_read_en;
    if (s_int_read_en) s_int_read_data <= s_mem[s_int_addr0];
    s_int_write_done <= s_int_write_en;
    if (pre_go) begin
      for (int k = 0; k < 16; k++) begin
        q_mem[k] <= pre_val;
        s_mem[k] <= pre_val;
      end
    end else begin
      if (q_int_write_en) q_mem[q_int_addr0] <= q_int_write_data;
      if (s_int_write_en) s_mem[s_int_addr0] <= s_int_write_data;
    end
    if (reset && (A_int_write_en || p_int_write_en || r_int_write_en ||
                  A_int_addr0[3] || A_int_addr1[3] || p_int_addr0[3] ||
                  q_int_addr0[3] || r_int_addr0[3] || s_int_addr0[3]))
      viol <= viol + 1;
  end

  typedef struct packed {
    logic [63:0][31:0] a;
    logic [7:0][31:0]  p;
    logic [7:0][31:0]  r;
    logic [31:0]       pre;
    logic [7:0][31:0]  s_sum;
    logic [7:0][31:0]  q_sum;
  } vec_t;

  vec_t tv [5];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic quiet();
    return !(A_int_read_en | p_int_read_en | q_int_read_en | r_int_read_en | s_int_read_en |
             q_int_write_en | s_int_write_en) &&
           ({A_int_addr0, A_int_addr1, p_int_addr0, q_int_addr0, r_int_addr0, s_int_addr0} == '0) &&
           (q_int_write_data == '0) && (s_int_write_data == '0);
  endfunction

  task automatic preload(input logic [31:0] v);
    @(negedge clk);
    pre_val = v;
    pre_go  = 1'b1;
    @(negedge clk);
    pre_go  = 1'b0;
  endtask

  task automatic load_case(input int c);
    for (int ii = 0; ii < 8; ii++) begin
      for (int jj = 0; jj < 8; jj++) a_mem[ii][jj] = tv[c].a[ii*8+jj];
      p_mem[ii] = tv[c].p[ii];
      r_mem[ii] = tv[c].r[ii];
    end
    preload(tv[c].pre);
  endtask

  // Starts a run and returns work cycles until done (-1 on timeout).
  task automatic run_work(input bit wiggle, output int cyc);
    cyc = -1;
    @(negedge clk);
    go = 1'b1;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk);
      #1;
      if (wiggle && n == 50) go = 1'b0;
      if (wiggle && n == 150) go = 1'b1;
      if (done) begin
        cyc = n - 1;
        break;
      end
    end
  endtask

  task automatic check_results(input int c, input string tag);
    logic [31:0] base;
    base = ZINIT ? 32'h0 : tv[c].pre;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s s[%0d]", tag, k), s_mem[k], base + tv[c].s_sum[k]);
      chk($sformatf("%s q[%0d]", tag, k), q_mem[k], base + tv[c].q_sum[k]);
    end
  endtask

  task automatic finish_run(input string tag);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, " done_hold"}, 32'(done), 32'd1);
    @(negedge clk);
    go = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, " done_clear"}, 32'(done), 32'd0);
    chk({tag, " idle_quiet"}, 32'(quiet()), 32'd1);
  endtask

  initial begin
    int cyc;
    int v0;
    bit same;
    reset = 1'b0;
    go    = 1'b0;

    for (int c = 0; c < 5; c++) tv[c] = '0;
    for (int k = 0; k < 64; k++) tv[0].a[k] = 32'd1;
    for (int k = 0; k < 8; k++) begin
      tv[0].p[k] = 32'd1;  tv[0].r[k] = 32'd1;
      tv[0].s_sum[k] = 32'd8;  tv[0].q_sum[k] = 32'd8;
      tv[1].a[k*9] = 32'd1;
      tv[1].p[k] = 32'(k + 1);  tv[1].r[k] = 32'(10 * (k + 1));
      tv[1].q_sum[k] = 32'(k + 1);  tv[1].s_sum[k] = 32'(10 * (k + 1));
      tv[3].p[k] = 32'd3;  tv[3].r[k] = 32'd2;
      tv[3].s_sum[k] = 32'hFFFF_FFF0;  tv[3].q_sum[k] = 32'hFFFF_FFE8;
    end
    tv[2] = tv[1];
    tv[2].pre = 32'hDEAD_BEEF;
    for (int k = 0; k < 64; k++) tv[3].a[k] = 32'hFFFF_FFFF;
    tv[4].a[0] = 32'h0001_0000;
    tv[4].p[0] = 32'h0001_0000;
    tv[4].r[0] = 32'h0001_0000;
    tv[4].pre  = 32'h1234_5678;

    repeat (3) @(posedge clk);
    #1;
    chk("reset done", 32'(done), 32'd0);
    chk("reset quiet", 32'(quiet()), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("idle quiet", 32'(quiet()), 32'd1);

    for (int c = 0; c < 5; c++) begin
      load_case(c);
      v0 = viol;
      run_work(c == 1, cyc);
      chk($sformatf("case%0d cycles", c), 32'(cyc), 32'(EXP_CYC));
      finish_run($sformatf("case%0d", c));
      check_results(c, $sformatf("case%0d", c));
      same = 1'b1;
      for (int ii = 0; ii < 8; ii++) begin
        for (int jj = 0; jj < 8; jj++) if (a_mem[ii][jj] !== tv[c].a[ii*8+jj]) same = 1'b0;
        if (p_mem[ii] !== tv[c].p[ii] || r_mem[ii] !== tv[c].r[ii]) same = 1'b0;
      end
      chk($sformatf("case%0d apr_unchanged", c), 32'(same), 32'd1);
      chk($sformatf("case%0d port_violations", c), 32'(viol - v0), 32'd0);
    end

    // Abort a run with reset at work cycle 100, then restart on all-ones data.
    load_case(3);
    @(negedge clk);
    go = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b0;
    go    = 1'b0;
    #1;
    chk("midreset done", 32'(done), 32'd0);
    chk("midreset quiet", 32'(quiet()), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("midreset done_hold", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    load_case(0);
    run_work(1'b0, cyc);
    chk("restart cycles", 32'(cyc), 32'(EXP_CYC));
    finish_run("restart");
    check_results(0, "restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bicg_main.md
# bicg_main

Fixed-size BiCG sub-kernel accelerator. It computes s = Aᵀ·r and q = A·p for an 8×8 matrix of 32-bit integers. Operands and results live in external sequential-read memories: one 2-D memory (A) and four 1-D memories (p, q, r, s). The block sits under the simulation/top wrapper as the compute core, and the wrapper owns the memories.

## Interface
Parameters (fixed):
- N, 8, matrix/vector dimension
- WIDTH, 32, data width
- IDX, 4, address width per dimension

Ports:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- go  in  1  start request, level-sensitive
- done  out  1  completion flag
- A_int_addr0 / A_int_addr1  out  4 each  row i / column j
- {A,p,q,r,s}_int_write_data  out  32  store data
- {A,p,q,r,s}_int_write_en  out  1  store strobe
- {A,p,q,r,s}_int_read_en  out  1  load strobe
- {A,p,q,r,s}_int_read_data  in  32  load data
- {A,p,q,r,s}_int_read_done  in  1  load-complete strobe
- {A,p,q,r,s}_int_write_done  in  1  store-complete strobe
- {p,q,r,s}_int_addr0  out  4  element index

## Operation
- Kernel: for i in 0..7, for j in 0..7: s[j] += r[i]*A[i][j]; q[i] += A[i][j]*p[j].
- Arithmetic is 32-bit two's complement. Products keep the low 32 bits, and sums wrap modulo 2^32.
- A and p are never written, so A_write_en and p_write_en are tied to 0. r is read-only.
- Memory protocol:
  - A read is issued by asserting read_en with a stable address for one cycle. read_data is captured in the next cycle, qualified by read_done.
  - A write asserts write_en with address and data for one cycle. Data commits at that edge, and write_done follows one cycle later.
- FSM states: IDLE, ZERO_S, LD_R, RD, ACC, WR_WAIT, WR_Q, WR_Q_WAIT, DONE.
  - IDLE: when go=1, go to ZERO_S.
  - ZERO_S: for j=0..7, issue write s[j]=0, then wait for write_done (2 cycles per element).
  - LD_R: issue read of r[i], then capture r_i into a register (2 cycles). q_acc is cleared.
  - RD: issue reads of A[i][j], p[j] and s[j] in parallel (separate memories).
  - ACC: read_done is high. Issue write s[j] = s + r_i·a, and update q_acc += a·p.
  - WR_WAIT: wait for s write_done. If j<7, increment j and go to RD; otherwise go to WR_Q.
  - WR_Q / WR_Q_WAIT: write q[i]=q_acc and wait for write_done. Then increment i and go to LD_R, or go to DONE after i=7.
  - DONE: done=1 while go stays high. When go=0, return to IDLE.
- go is ignored outside IDLE and DONE.
- In IDLE and DONE, all enables, addresses and write data are driven to 0.

## Timing
- Reset values: state=IDLE, i=j=0, all registers and outputs 0, done=0.
- Each j iteration takes 3 cycles. Each row takes 2 + 24 + 2 = 28 cycles. ZERO_S takes 16 cycles.
- With the default build (BICG_ZERO_INIT_EN defined), exactly 240 cycles are spent between leaving IDLE and entering DONE. With the macro undefined, the count is 224.
- done rises the cycle after the final q write_done.
- Reset asserted mid-run: the block returns to IDLE immediately, and memory keeps whatever partial contents it holds. A restart recomputes from scratch.
- Address boundary: indices run 0..7 only. Bit 3 of every address is always 0, and j/i wrap to 0 only at row or kernel end.

## Configuration
- BICG_ZERO_INIT_EN, defined by default.
  - Defined: ZERO_S runs, and q_acc starts at 0 for each row. Results are independent of the preloaded s and q contents.
  - Undefined: ZERO_S is skipped. LD_R also reads q[i] in parallel with r[i], and q_acc starts from that value. s and q accumulate onto their preloaded contents.

## Structure
- Package bicg_pkg holds N, WIDTH, IDX, the state enum, and the cycle constants (ROW_CYCLES=28, ZERO_CYCLES=16).
- One sub-module, bicg_mac: a combinational 32-bit dual multiply-add, s_new = s + r·a and q_new = q + a·p, both wrapping.
- The FSM, counters and memory-port drive stay in bicg_main.

## Test plan
- All A, r, p = 1, default build -> every s[j]=8 and q[i]=8; done after 240 work cycles.
- A=identity, p=[1..8], r=[10,20..80] -> q=[1..8], s=[10..80]; A, p and r are unchanged.
- s and q preloaded with 0xDEADBEEF, default build -> results are identical to the case above. With the macro undefined -> each element is 0xDEADBEEF plus the sum, mod 2^32.
- A all 0xFFFFFFFF, r all 2, p all 3 -> s[j]=0xFFFFFFF0, q[i]=0xFFFFFFE8.
- A[0][0]=0x10000, p[0]=0x10000, r[0]=0x10000, others 0 -> q[0]=0, s[0]=0, all other elements 0.
- Reset pulsed low at work cycle 100, then go reasserted with all-ones data -> all s and q elements = 8; done 240 cycles after restart; done stays 0 during reset.
